wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage and register-file write port driver. It accepts one retiring instruction per handshake from the MEM side: an ALU result, a destination register and the 2-bit WB control field that `decode` emits. It then produces the single-cycle write strobe (`rw`), register index (`dst`) and data (`W1`) consumed by `decode`'s register file. Loads wait for a variable-latency memory return, guarded by a timeout. Pending-load information is exported so hazard logic can stall dependent reads.

## Interface
Parameters:
- `LOAD_TIMEOUT`, default 255: maximum cycles spent in WAIT_LOAD before the load is abandoned; range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  MEM side presents an instruction.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_wb`  in  2  WB control; bit0 = reg_write, bit1 = mem_to_reg (load).
- `in_dst`  in  3  destination register index.
- `in_alu`  in  32  ALU result.
- `mem_valid`  in  1  load data return strobe.
- `mem_rdata`  in  32  load data.
- `rw`  out  1  register-file write enable, one-cycle pulse.
- `dst`  out  3  write index; held until next write.
- `W1`  out  32  write data; held until next write.
- `pending_valid`  out  1  a load is outstanding.
- `pending_dst`  out  3  destination of the outstanding load.
- `err`  out  1  sticky: load timeout or unsolicited `mem_valid`.

## Operation
- States: IDLE, WAIT_LOAD.
- Acceptance happens when `in_valid && in_ready` at a rising edge.
- IDLE, accept, `in_wb[1]==0`:
  - if `in_wb[0]==1` and `in_dst!=0`: next cycle `rw`=1, `dst`=`in_dst`, `W1`=`in_alu`.
  - otherwise: no write.
  - state stays IDLE.
- IDLE, accept, `in_wb[1]==1`:
  - capture `in_dst` and `in_wb[0]`.
  - if `mem_valid` is high in the same cycle, complete immediately: write `mem_rdata` next cycle and stay IDLE.
  - otherwise go to WAIT_LOAD and clear the timeout counter.
- WAIT_LOAD:
  - `mem_valid` high: write `mem_rdata` to the captured dst (if reg_write and dst!=0) next cycle, then return to IDLE.
  - `mem_valid` low: counter increments by 1.
  - counter reaches `LOAD_TIMEOUT`: return to IDLE with no write, and set `err`.
- `mem_valid` in IDLE without an accepting load: ignored for data, sets `err`.
- Writes to r0 are always suppressed; r0 stays architecturally zero.
- `pending_valid` = (state == WAIT_LOAD); `pending_dst` = captured dst, which is 0 when not pending.
- `err` clears only on `rst`.

## Timing
- Reset values: `rw`=0, `dst`=0, `W1`=0, `pending_valid`=0, `pending_dst`=0, `err`=0, state IDLE (`in_ready`=1), counter 0.
- ALU op accepted at edge N: `rw` high for the cycle after N only.
- Load returning at edge M (M ≥ acceptance edge): `rw` high the cycle after M.
- Load-to-load throughput: the next instruction is accepted no earlier than the edge after the completing `mem_valid` (`in_ready` is low throughout WAIT_LOAD).
- Timeout: abort occurs at the edge where counter == `LOAD_TIMEOUT`; `in_ready` rises the following cycle.
- `mem_valid` on the same edge as the timeout: data wins; write performed, no `err`.
- `rst` asserted mid-WAIT_LOAD: immediate return to IDLE; the load is dropped; any `rw` pulse in flight is cleared.
- `rw`, `dst`, `W1` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `wb_pkg`:
  - WB bit index constants `WB_REG_WRITE=0`, `WB_MEM_TO_REG=1`.
  - state enum {IDLE, WAIT_LOAD}.
  - default timeout constant.
- One natural sub-module, `wb_load_timer`: clear/enable/expire counter, 8-bit, parameterised by `LOAD_TIMEOUT`.

## Test plan
- Reset, then ALU op `in_wb`=01, `in_dst`=3, `in_alu`=0x1234 → `rw`=1 for exactly one cycle with `dst`=3, `W1`=0x1234; `in_ready` stays 1.
- ALU op to r0 with `in_wb`=01 → `rw` stays 0; `dst`/`W1` keep their prior values.
- Load `in_wb`=11, `in_dst`=5; `mem_valid` 4 cycles later with 0xDEADBEEF:
  - `pending_valid`=1 and `pending_dst`=5 during the wait, `in_ready`=0.
  - then `rw` pulse with `W1`=0xDEADBEEF, `dst`=5.
- Load accepted with `mem_valid` in the same cycle (`mem_rdata`=0x7) → write the next cycle; `pending_valid` never rises.
- `LOAD_TIMEOUT`=8, load with no return → abort after 8 wait cycles, `err`=1, no `rw`; a later `mem_valid` in IDLE keeps `err`=1 and does not write.
- `rst` pulsed while in WAIT_LOAD → all outputs return to reset values and `in_ready`=1 immediately; the next ALU op writes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   - bit positions inside the 2-bit WB control field produced by decode
//   - writeback FSM state encoding
//   - default load-timeout value
//   - small helper deciding whether a write actually reaches the register file
package wb_pkg;

  localparam int WB_REG_WRITE = 0;
  localparam int WB_MEM_TO_REG = 1;

  localparam int LOAD_TIMEOUT_DEFAULT = 255;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // r0 is architecturally zero, so a write to it never produces a strobe.
  function automatic logic wb_write_allowed(input logic reg_write, input logic [2:0] dst);
    return reg_write && (dst != 3'd0);
  endfunction

endpackage

// File: rtl/wb_load_timer.sv
// wb_load_timer: 8-bit load timeout counter.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   clear_i   in   force counter to zero (has priority over enable)
//   enable_i  in   count one more waiting cycle
//   expire_o  out  high when this enabled cycle brings the count up to LOAD_TIMEOUT
module wb_load_timer
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  // Value held by the counter in the last cycle allowed before abort.
  localparam logic [7:0] LAST_COUNT = 8'(LOAD_TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged on the edge where the counter would reach LOAD_TIMEOUT,
  // so the stage spends exactly LOAD_TIMEOUT cycles waiting.
  assign expire_o = enable_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the register-file write port.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   handshake with the MEM side (ready only in IDLE)
//   in_wb[1:0]            bit0 reg_write, bit1 mem_to_reg (load)
//   in_dst, in_alu        destination index and ALU result
//   mem_valid, mem_rdata  load data return
//   rw, dst, W1           registered write strobe (1-cycle), index, data
//   pending_valid/_dst    outstanding load, for hazard stalling
//   err                   sticky: load timeout or unsolicited mem_valid
module wb_stage
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_wb,
  input  logic [2:0]  in_dst,
  input  logic [31:0] in_alu,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        rw,
  output logic [2:0]  dst,
  output logic [31:0] W1,
  output logic        pending_valid,
  output logic [2:0]  pending_dst,
  output logic        err
);

  wb_state_e   state_q, state_d;
  logic        rw_q, rw_d;
  logic [2:0]  dst_q, dst_d;
  logic [31:0] w1_q, w1_d;
  logic        err_q, err_d;
  logic [2:0]  pdst_q, pdst_d;
  logic        pwe_q, pwe_d;
  logic        timer_clear_s;
  logic        timer_enable_s;
  logic        timer_expire_s;

  assign timer_clear_s  = (state_q != WAIT_LOAD);
  assign timer_enable_s = (state_q == WAIT_LOAD) && !mem_valid;

  wb_load_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear_s),
    .enable_i (timer_enable_s),
    .expire_o (timer_expire_s)
  );

  // Next-state and next-output logic of the writeback FSM.
  always_comb begin
    state_d = state_q;
    rw_d    = 1'b0;
    dst_d   = dst_q;
    w1_d    = w1_q;
    err_d   = err_q;
    pdst_d  = pdst_q;
    pwe_d   = pwe_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_wb[WB_MEM_TO_REG]) begin
          if (mem_valid) begin
            // Data already present: complete the load without waiting.
            if (wb_write_allowed(in_wb[WB_REG_WRITE], in_dst)) begin
              rw_d  = 1'b1;
              dst_d = in_dst;
              w1_d  = mem_rdata;
            end else begin
              rw_d  = 1'b0;
            end
          end else begin
            state_d = WAIT_LOAD;
            pdst_d  = in_dst;
            pwe_d   = in_wb[WB_REG_WRITE];
          end
        end else if (in_valid) begin
          if (wb_write_allowed(in_wb[WB_REG_WRITE], in_dst)) begin
            rw_d  = 1'b1;
            dst_d = in_dst;
            w1_d  = in_alu;
          end else begin
            rw_d  = 1'b0;
          end
          // A return strobe with no load being accepted is unsolicited.
          if (mem_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          if (mem_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      WAIT_LOAD: begin
        // mem_valid is checked first so data beats a simultaneous timeout.
        if (mem_valid) begin
          if (wb_write_allowed(pwe_q, pdst_q)) begin
            rw_d  = 1'b1;
            dst_d = pdst_q;
            w1_d  = mem_rdata;
          end else begin
            rw_d  = 1'b0;
          end
          state_d = IDLE;
          pdst_d  = 3'd0;
          pwe_d   = 1'b0;
        end else if (timer_expire_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
          pdst_d  = 3'd0;
          pwe_d   = 1'b0;
        end else begin
          state_d = WAIT_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        pdst_d  = 3'd0;
        pwe_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      dst_q   <= 3'd0;
      w1_q    <= 32'd0;
      err_q   <= 1'b0;
      pdst_q  <= 3'd0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      dst_q   <= dst_d;
      w1_q    <= w1_d;
      err_q   <= err_d;
      pdst_q  <= pdst_d;
      pwe_q   <= pwe_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign pending_valid = (state_q == WAIT_LOAD);
  assign pending_dst   = pdst_q;
  assign rw            = rw_q;
  assign dst           = dst_q;
  assign W1            = w1_q;
  assign err           = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage (LOAD_TIMEOUT = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb;
  logic [2:0]  in_dst;
  logic [31:0] in_alu;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        rw;
  logic [2:0]  dst;
  logic [31:0] W1;
  logic        pending_valid;
  logic [2:0]  pending_dst;
  logic        err;

  int n_checks;
  int n_pass;

  wb_stage #(
    .LOAD_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wb         (in_wb),
    .in_dst        (in_dst),
    .in_alu        (in_alu),
    .mem_valid     (mem_valid),
    .mem_rdata     (mem_rdata),
    .rw            (rw),
    .dst           (dst),
    .W1            (W1),
    .pending_valid (pending_valid),
    .pending_dst   (pending_dst),
    .err           (err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_wb     = 2'b00;
    in_dst    = 3'd0;
    in_alu    = 32'd0;
    mem_valid = 1'b0;
    mem_rdata = 32'd0;
  endtask

  task automatic present(input logic [1:0] wb, input logic [2:0] d, input logic [31:0] alu);
    in_valid = 1'b1;
    in_wb    = wb;
    in_dst   = d;
    in_alu   = alu;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_val("rst_rw", {31'd0, rw}, 32'd0);
    check_val("rst_dst", {29'd0, dst}, 32'd0);
    check_val("rst_w1", W1, 32'd0);
    check_val("rst_pv", {31'd0, pending_valid}, 32'd0);
    check_val("rst_pd", {29'd0, pending_dst}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);

    // ALU op to r3
    present(2'b01, 3'd3, 32'h0000_1234);
    @(negedge clk);
    idle_inputs();
    check_val("alu_rw", {31'd0, rw}, 32'd1);
    check_val("alu_dst", {29'd0, dst}, 32'd3);
    check_val("alu_w1", W1, 32'h0000_1234);
    check_val("alu_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_val("alu_rw_one_cycle", {31'd0, rw}, 32'd0);
    check_val("alu_dst_hold", {29'd0, dst}, 32'd3);

    // ALU op to r0 is suppressed
    present(2'b01, 3'd0, 32'h0000_5555);
    @(negedge clk);
    idle_inputs();
    check_val("r0_rw", {31'd0, rw}, 32'd0);
    check_val("r0_dst", {29'd0, dst}, 32'd3);
    check_val("r0_w1", W1, 32'h0000_1234);

    // reg_write clear: no write
    present(2'b00, 3'd4, 32'h0000_9999);
    @(negedge clk);
    idle_inputs();
    check_val("nowe_rw", {31'd0, rw}, 32'd0);
    check_val("nowe_w1", W1, 32'h0000_1234);

    // Load to r5, data returns 4 cycles after acceptance
    present(2'b11, 3'd5, 32'h0000_0000);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check_val("ld_pv", {31'd0, pending_valid}, 32'd1);
      check_val("ld_pd", {29'd0, pending_dst}, 32'd5);
      check_val("ld_ready", {31'd0, in_ready}, 32'd0);
      check_val("ld_rw_wait", {31'd0, rw}, 32'd0);
      @(negedge clk);
    end
    check_val("ld_pv_last", {31'd0, pending_valid}, 32'd1);
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    check_val("ld_rw", {31'd0, rw}, 32'd1);
    check_val("ld_dst", {29'd0, dst}, 32'd5);
    check_val("ld_w1", W1, 32'hDEAD_BEEF);
    check_val("ld_pv_done", {31'd0, pending_valid}, 32'd0);
    check_val("ld_pd_done", {29'd0, pending_dst}, 32'd0);
    check_val("ld_ready_done", {31'd0, in_ready}, 32'd1);
    check_val("ld_err", {31'd0, err}, 32'd0);

    // Load completing in the accept cycle
    present(2'b11, 3'd6, 32'h0000_0000);
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_0007;
    @(negedge clk);
    idle_inputs();
    check_val("imm_rw", {31'd0, rw}, 32'd1);
    check_val("imm_dst", {29'd0, dst}, 32'd6);
    check_val("imm_w1", W1, 32'h0000_0007);
    check_val("imm_pv", {31'd0, pending_valid}, 32'd0);
    check_val("imm_err", {31'd0, err}, 32'd0);

    // Load timeout: 8 waiting cycles, then abort with err
    present(2'b11, 3'd2, 32'h0000_0000);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      check_val("to_pv", {31'd0, pending_valid}, 32'd1);
      check_val("to_err_wait", {31'd0, err}, 32'd0);
      @(negedge clk);
    end
    check_val("to_pv_done", {31'd0, pending_valid}, 32'd0);
    check_val("to_ready", {31'd0, in_ready}, 32'd1);
    check_val("to_err", {31'd0, err}, 32'd1);
    check_val("to_rw", {31'd0, rw}, 32'd0);
    check_val("to_w1", W1, 32'h0000_0007);
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_AAAA;
    @(negedge clk);
    idle_inputs();
    check_val("late_err", {31'd0, err}, 32'd1);
    check_val("late_rw", {31'd0, rw}, 32'd0);
    check_val("late_w1", W1, 32'h0000_0007);

    // Reset in the middle of a load wait
    present(2'b11, 3'd4, 32'h0000_0000);
    @(negedge clk);
    idle_inputs();
    check_val("mr_pv_before", {31'd0, pending_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("mr_pv", {31'd0, pending_valid}, 32'd0);
    check_val("mr_pd", {29'd0, pending_dst}, 32'd0);
    check_val("mr_ready", {31'd0, in_ready}, 32'd1);
    check_val("mr_err", {31'd0, err}, 32'd0);
    check_val("mr_dst", {29'd0, dst}, 32'd0);
    check_val("mr_w1", W1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    present(2'b01, 3'd7, 32'h0000_CAFE);
    @(negedge clk);
    idle_inputs();
    check_val("mr_alu_rw", {31'd0, rw}, 32'd1);
    check_val("mr_alu_dst", {29'd0, dst}, 32'd7);
    check_val("mr_alu_w1", W1, 32'h0000_CAFE);

    // Data arriving on the timeout edge wins
    present(2'b11, 3'd1, 32'h0000_0000);
    @(negedge clk);
    idle_inputs();
    repeat (7) @(negedge clk);
    check_val("edge_pv", {31'd0, pending_valid}, 32'd1);
    mem_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    idle_inputs();
    check_val("edge_rw", {31'd0, rw}, 32'd1);
    check_val("edge_dst", {29'd0, dst}, 32'd1);
    check_val("edge_w1", W1, 32'h1234_5678);
    check_val("edge_err", {31'd0, err}, 32'd0);

    // Unsolicited mem_valid in IDLE sets err without writing
    mem_valid = 1'b1;
    mem_rdata = 32'h0000_BBBB;
    @(negedge clk);
    idle_inputs();
    check_val("unsol_err", {31'd0, err}, 32'd1);
    check_val("unsol_rw", {31'd0, rw}, 32'd0);
    check_val("unsol_w1", W1, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
